// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer
//   Stall and flush control for the 5-stage MIPS pipeline. It combines four
//   conditions into one set of pipeline-register load enables:
//     - data-memory wait (memReq without memAck) freezes the whole pipe,
//     - load-use and HI/LO-while-MDU-busy hazards hold PC and IF/ID and inject
//       a bubble into ID/EX,
//     - a taken branch squashes the instruction sitting in IF/ID.
//   It also keeps the multi-cycle mult/div busy counter, a memory-wait
//   timeout with a sticky error flag, and a saturating count of cycles in
//   which the PC did not advance.
//
//   All enables are combinational from the current inputs and registered
//   state, so a hazard takes effect in the same cycle it is detected.
module pipeline_hazard_sequencer #(
  parameter int MDU_LATENCY = 32,
  parameter int MEM_TIMEOUT = 64,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   IDEXMemRead,
  input  logic [4:0]             IDEXRt,
  input  logic [4:0]             IFIDRs,
  input  logic [4:0]             IFIDRt,
  input  logic                   IFIDUsesHiLo,
  input  logic                   mduStart,
  input  logic                   branchTaken,
  input  logic                   memReq,
  input  logic                   memAck,
  output logic                   PCWrite,
  output logic                   IFIDWrite,
  output logic                   IDEXWrite,
  output logic                   EXMEMWrite,
  output logic                   ctrlSetZero,
  output logic                   IFIDFlush,
  output logic                   mduBusy,
  output logic                   memErr,
  output logic [STALL_CNT_W-1:0] stallCount
);

  // Counter widths: each counter must be able to hold its full load/limit
  // value, so size them for value+1 states.
  localparam int MDU_CNT_W  = $clog2(MDU_LATENCY + 1);
  localparam int WAIT_CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [MDU_CNT_W-1:0]  MDU_LOAD    = MDU_CNT_W'(MDU_LATENCY);
  localparam logic [MDU_CNT_W-1:0]  MDU_ONE     = MDU_CNT_W'(1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX    = WAIT_CNT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_CNT_W-1:0] WAIT_ERR_AT = WAIT_CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_ONE    = WAIT_CNT_W'(1);
  localparam logic [STALL_CNT_W-1:0] STALL_ONE  = STALL_CNT_W'(1);

  // RUN: no outstanding memory wait. MEM_WAIT: the previous cycle was a
  // memory freeze and the access has not yet completed or been dropped.
  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  state_e                  state_q,     state_d;
  logic [MDU_CNT_W-1:0]    mdu_cnt_q,   mdu_cnt_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q,  wait_cnt_d;
  logic                    mem_err_q,   mem_err_d;
  logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic mem_freeze;
  logic load_use;
  logic mdu_busy;
  logic mdu_haz;
  logic rt_match;

  // Hazard detection from current inputs and registered MDU state.
  always_comb begin
    mem_freeze = memReq & ~memAck;
    // Register $zero never carries a real dependency, so a load into r0
    // must not stall the pipe.
    rt_match   = (IDEXRt == IFIDRs) | (IDEXRt == IFIDRt);
    load_use   = IDEXMemRead & (IDEXRt != 5'd0) & rt_match;
    mdu_busy   = (mdu_cnt_q != '0);
    mdu_haz    = mdu_busy & IFIDUsesHiLo;
  end

  // Prioritised enable generation: memory freeze > data hazard > branch.
  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path
    // leaves a signal unassigned; that is what keeps this block latch-free.
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    EXMEMWrite  = 1'b1;
    ctrlSetZero = 1'b0;
    IFIDFlush   = 1'b0;

    if (rst) begin
      // Let the pipeline registers clear themselves while reset is held.
    end else if (mem_freeze) begin
      // Whole pipe holds; nothing moves until memory answers.
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMWrite = 1'b0;
    end else if (load_use | mdu_haz) begin
      // Hold the dependent instruction in ID and push a bubble forward.
      // A branch resolved this cycle is ignored: it re-resolves next cycle
      // with the correct operands.
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      ctrlSetZero = 1'b1;
    end else if (branchTaken) begin
      IFIDFlush = 1'b1;
    end
  end

  assign mduBusy    = mdu_busy;
  assign memErr     = mem_err_q;
  assign stallCount = stall_cnt_q;

  // Memory-wait FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_freeze) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (memAck | ~memReq) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Memory-wait length counter and sticky timeout flag.
  always_comb begin
    wait_cnt_d = '0;
    mem_err_d  = mem_err_q;
    if (mem_freeze) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q
                                            : wait_cnt_q + WAIT_ONE;
      // wait_cnt_q counts freeze cycles already completed, so this is the
      // MEM_TIMEOUT-th consecutive one when it has reached MEM_TIMEOUT-1.
      if (wait_cnt_q >= WAIT_ERR_AT) mem_err_d = 1'b1;
    end
  end

  // Mult/div busy countdown. A start is only accepted when the EX stage is
  // actually advancing; a frozen start is re-presented later.
  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (mduStart & ~mem_freeze) begin
      mdu_cnt_d = MDU_LOAD;
    end else if (mdu_busy) begin
      mdu_cnt_d = mdu_cnt_q - MDU_ONE;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (~PCWrite && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_ONE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so
    // every flop samples the pre-edge values computed above.
    if (rst) begin
      state_q     <= ST_RUN;
      mdu_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mdu_cnt_q   <= mdu_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// tb_pipeline_hazard_sequencer
//   Directed hazard scenarios followed by random traffic. A driver applies
//   one stimulus per cycle and pushes the expected outputs computed by a
//   cycle-level reference model; a monitor pops and compares on the falling
//   edge.
module tb_pipeline_hazard_sequencer;

  localparam int MDU_LAT = 4;
  localparam int MEM_TO  = 8;
  localparam int STALL_W = 5;
  localparam int STALL_MAX = (1 << STALL_W) - 1;

  typedef struct packed {
    logic       rst;
    logic       mem_read;
    logic [4:0] idex_rt;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       hilo;
    logic       mdu_start;
    logic       branch;
    logic       mem_req;
    logic       mem_ack;
  } stim_t;

  typedef struct packed {
    logic [5:0]         ctl;   // {PC,IFID,IDEX,EXMEM,ctrlSetZero,IFIDFlush}
    logic               busy;
    logic               err;
    logic [STALL_W-1:0] stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic IDEXMemRead = 1'b0, IFIDUsesHiLo = 1'b0, mduStart = 1'b0;
  logic branchTaken = 1'b0, memReq = 1'b0, memAck = 1'b0;
  logic [4:0] IDEXRt = '0, IFIDRs = '0, IFIDRt = '0;
  logic PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, ctrlSetZero, IFIDFlush;
  logic mduBusy, memErr;
  logic [STALL_W-1:0] stallCount;

  always #5 clk = ~clk;

  pipeline_hazard_sequencer #(
    .MDU_LATENCY(MDU_LAT), .MEM_TIMEOUT(MEM_TO), .STALL_CNT_W(STALL_W)
  ) dut (
    .clk(clk), .rst(rst),
    .IDEXMemRead(IDEXMemRead), .IDEXRt(IDEXRt),
    .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IFIDUsesHiLo(IFIDUsesHiLo),
    .mduStart(mduStart), .branchTaken(branchTaken),
    .memReq(memReq), .memAck(memAck),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .EXMEMWrite(EXMEMWrite), .ctrlSetZero(ctrlSetZero), .IFIDFlush(IFIDFlush),
    .mduBusy(mduBusy), .memErr(memErr), .stallCount(stallCount)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // Reference model state: cycle-indexed rather than counter-based.
  int cyc        = 0;  // index of the cycle currently being driven
  int mdu_ready  = 0;  // first cycle at which the MDU result is valid
  int freeze_run = 0;  // consecutive memory-freeze cycles so far
  bit m_err      = 0;
  int m_stalls   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs the spec demands.
  task automatic drive(input stim_t s);
    exp_t e;
    bit freeze, lu, busy;
    @(posedge clk);
    #1;
    rst = s.rst; IDEXMemRead = s.mem_read; IDEXRt = s.idex_rt;
    IFIDRs = s.ifid_rs; IFIDRt = s.ifid_rt; IFIDUsesHiLo = s.hilo;
    mduStart = s.mdu_start; branchTaken = s.branch;
    memReq = s.mem_req; memAck = s.mem_ack;

    freeze = s.mem_req && !s.mem_ack;
    lu     = s.mem_read && s.idex_rt != 0 &&
             (s.idex_rt == s.ifid_rs || s.idex_rt == s.ifid_rt);
    busy   = cyc < mdu_ready;

    if (s.rst)                   e.ctl = 6'b111100;
    else if (freeze)             e.ctl = 6'b000000;
    else if (lu || (busy && s.hilo)) e.ctl = 6'b001110;
    else if (s.branch)           e.ctl = 6'b111101;
    else                         e.ctl = 6'b111100;
    e.busy  = busy;
    e.err   = m_err;
    e.stall = STALL_W'(m_stalls);
    sb.push_back(e);

    if (s.rst) begin
      freeze_run = 0; m_err = 0; m_stalls = 0; mdu_ready = 0;
    end else begin
      freeze_run = freeze ? freeze_run + 1 : 0;
      if (freeze_run >= MEM_TO) m_err = 1;
      if (!e.ctl[5] && m_stalls < STALL_MAX) m_stalls++;
      if (s.mdu_start && !freeze) mdu_ready = cyc + 1 + MDU_LAT;
    end
    cyc++;
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("enables", 32'({PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
                              ctrlSetZero, IFIDFlush}), 32'(e.ctl));
        check("mduBusy", 32'(mduBusy), 32'(e.busy));
        check("memErr", 32'(memErr), 32'(e.err));
        check("stallCount", 32'(stallCount), 32'(e.stall));
      end
    end
  end

  function automatic stim_t idle();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst       = ($urandom_range(0, 299) == 0);
    s.mem_read  = 1'($urandom_range(0, 1));
    s.idex_rt   = 5'($urandom_range(0, 3));
    s.ifid_rs   = 5'($urandom_range(0, 3));
    s.ifid_rt   = 5'($urandom_range(0, 3));
    s.hilo      = 1'($urandom_range(0, 1));
    s.mdu_start = ($urandom_range(0, 7) == 0);
    s.branch    = ($urandom_range(0, 2) == 0);
    s.mem_req   = ($urandom_range(0, 2) == 0);
    s.mem_ack   = ($urandom_range(0, 1) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    // Reset cycle.
    s = idle(); s.rst = 1; drive(s);

    // Load-use on rs, then a load into r0 that must not stall.
    s = idle(); s.mem_read = 1; s.idex_rt = 8; s.ifid_rs = 8; drive(s);
    drive(idle());
    s = idle(); s.mem_read = 1; drive(s);
    // Load-use through rt.
    s = idle(); s.mem_read = 1; s.idex_rt = 9; s.ifid_rt = 9; drive(s);

    // MDU busy with a HI/LO consumer waiting in ID.
    s = idle(); s.rst = 1; drive(s);
    s = idle(); s.mdu_start = 1; drive(s);
    for (int i = 0; i < 6; i++) begin
      s = idle(); s.hilo = 1; drive(s);
    end

    // Three-cycle memory wait then ack.
    s = idle(); s.rst = 1; drive(s);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.mem_req = 1; drive(s);
    end
    s = idle(); s.mem_req = 1; s.mem_ack = 1; drive(s);
    drive(idle());

    // Ten-cycle wait crosses the timeout; flag stays until reset.
    for (int i = 0; i < 10; i++) begin
      s = idle(); s.mem_req = 1; drive(s);
    end
    s = idle(); s.mem_req = 1; s.mem_ack = 1; drive(s);
    repeat (3) drive(idle());
    s = idle(); s.rst = 1; drive(s);
    drive(idle());

    // Branch during a load-use stall is deferred, then flushes.
    s = idle(); s.mem_read = 1; s.idex_rt = 5; s.ifid_rs = 5; s.branch = 1;
    drive(s);
    s = idle(); s.branch = 1; drive(s);

    // Reset while the MDU is mid-count.
    s = idle(); s.mdu_start = 1; drive(s);
    drive(idle()); drive(idle());
    s = idle(); s.rst = 1; drive(s);
    drive(idle());
    // Start presented during a memory freeze is not accepted.
    s = idle(); s.mem_req = 1; s.mdu_start = 1; drive(s);
    s = idle(); s.hilo = 1; drive(s);
    drive(idle());

    // Random traffic with periodic long waits to reach the timeout.
    for (int i = 0; i < 3000; i++) begin
      s = rand_stim();
      if ((i % 400) >= 380) begin
        s.rst = 0; s.mem_req = 1; s.mem_ack = ((i % 400) == 399);
      end
      drive(s);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
